// File: rtl/uart_rx_ext.sv
// UART receiver with configurable parity/stop bits that packs NUM_WORDS
// received words into one beat and queues beats in a valid/ready FIFO.
module uart_rx_ext #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int W_OUT            = 16,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W_OUT-1:0] m_data,
  output logic             m_perr,
  output logic             m_ferr,
  output logic             overflow
);

  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int TW  = $clog2(CLOCKS_PER_PULSE);
  localparam int BW  = $clog2(BITS_PER_WORD) + 1;
  localparam int WCW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = W_OUT + 2;
  localparam int PAR_ODD  = 32'sd1;
  localparam int PAR_EVEN = 32'sd2;

  localparam logic [TW-1:0]  HALF_M1   = TW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [TW-1:0]  FULL_M1   = TW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0]  LAST_DATA = BW'(BITS_PER_WORD - 1);
  localparam logic [BW-1:0]  LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);
  localparam logic [AW:0]    FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_error(input logic [BITS_PER_WORD-1:0] data, input logic par_bit);
    logic sum;
    sum = (^data) ^ par_bit;
    if (PARITY == PAR_ODD) begin
      return ~sum;
    end else if (PARITY == PAR_EVEN) begin
      return sum;
    end else begin
      return 1'b0;
    end
  endfunction

  state_t                   state_r, state_next_s;
  logic [1:0]               sync_r;
  logic                     rxs;
  logic [TW-1:0]            tick_r;
  logic [BW-1:0]            bit_cnt_r;
  logic [BITS_PER_WORD-1:0] shift_r;
  logic                     word_perr_r, word_ferr_r, word_ferr_s;
  logic                     sample_s, word_done_s, last_word_s, push_s;
  logic [WCW-1:0]           word_cnt_r;
  logic [W_OUT-1:0]         beat_data_r, beat_next_s;
  logic                     beat_perr_r, beat_ferr_r, beat_perr_s, beat_ferr_s;
  logic [EW-1:0]            mem_r [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_r, rd_ptr_r;
  logic [AW:0]              count_r;
  logic                     full_s, pop_s, wr_en_s;
  logic                     overflow_r;

  assign rxs      = sync_r[1];
  assign sample_s = (state_r != ST_IDLE) && (tick_r == {TW{1'b0}});

  // Two-flop synchroniser for the asynchronous rx pin; idles high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; word_done_s marks the final stop-bit sample.
  always_comb begin
    state_next_s = state_r;
    word_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rxs) state_next_s = ST_START;
        else      state_next_s = ST_IDLE;
      end
      ST_START: begin
        if (sample_s) begin
          if (rxs) state_next_s = ST_IDLE;
          else     state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (sample_s && (bit_cnt_r == LAST_DATA)) begin
          if (PARITY != 32'sd0) state_next_s = ST_PARITY;
          else                  state_next_s = ST_STOP;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (sample_s) state_next_s = ST_STOP;
        else          state_next_s = ST_PARITY;
      end
      ST_STOP: begin
        if (sample_s && (bit_cnt_r == LAST_STOP)) begin
          state_next_s = ST_IDLE;
          word_done_s  = 1'b1;
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Bit timing, deserialiser and per-word error capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_r      <= HALF_M1;
      bit_cnt_r   <= {BW{1'b0}};
      shift_r     <= {BITS_PER_WORD{1'b0}};
      word_perr_r <= 1'b0;
      word_ferr_r <= 1'b0;
    end else begin
      // Idle keeps the half-bit preload so the start bit is sampled mid-bit.
      if (state_r == ST_IDLE)             tick_r <= HALF_M1;
      else if (tick_r == {TW{1'b0}})      tick_r <= FULL_M1;
      else                                tick_r <= tick_r - TW'(1);

      if (state_next_s != state_r)        bit_cnt_r <= {BW{1'b0}};
      else if (sample_s)                  bit_cnt_r <= bit_cnt_r + BW'(1);
      else                                bit_cnt_r <= bit_cnt_r;

      if ((state_r == ST_DATA) && sample_s) shift_r <= {rxs, shift_r[BITS_PER_WORD-1:1]};
      else                                  shift_r <= shift_r;

      if (state_r == ST_START)                       word_perr_r <= 1'b0;
      else if ((state_r == ST_PARITY) && sample_s)   word_perr_r <= parity_error(shift_r, rxs);
      else                                           word_perr_r <= word_perr_r;

      if (state_r == ST_START)                       word_ferr_r <= 1'b0;
      else if ((state_r == ST_STOP) && sample_s && !rxs) word_ferr_r <= 1'b1;
      else                                           word_ferr_r <= word_ferr_r;
    end
  end

  // Beat assembly: insert the finishing word and merge its flags.
  always_comb begin
    beat_next_s = beat_data_r;
    beat_next_s[int'(word_cnt_r)*BITS_PER_WORD +: BITS_PER_WORD] = shift_r;
    word_ferr_s = word_ferr_r | ~rxs;
    beat_perr_s = beat_perr_r | word_perr_r;
    beat_ferr_s = beat_ferr_r | word_ferr_s;
    last_word_s = (word_cnt_r == LAST_WORD);
    push_s      = word_done_s && last_word_s;
  end

  // Beat register, word counter and accumulated flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_data_r <= {W_OUT{1'b0}};
      word_cnt_r  <= {WCW{1'b0}};
      beat_perr_r <= 1'b0;
      beat_ferr_r <= 1'b0;
    end else if (word_done_s) begin
      beat_data_r <= beat_next_s;
      if (last_word_s) begin
        word_cnt_r  <= {WCW{1'b0}};
        beat_perr_r <= 1'b0;
        beat_ferr_r <= 1'b0;
      end else begin
        word_cnt_r  <= word_cnt_r + WCW'(1);
        beat_perr_r <= beat_perr_s;
        beat_ferr_r <= beat_ferr_s;
      end
    end else begin
      beat_data_r <= beat_data_r;
      word_cnt_r  <= word_cnt_r;
      beat_perr_r <= beat_perr_r;
      beat_ferr_r <= beat_ferr_r;
    end
  end

  assign full_s  = (count_r == FULL_CNT);
  assign pop_s   = m_valid && m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en_s = push_s && (!full_s || pop_s);

  // Output FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {EW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= {beat_next_s, beat_perr_s, beat_ferr_s};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end

      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      else       rd_ptr_r <= rd_ptr_r;

      if (wr_en_s && !pop_s)      count_r <= count_r + (AW+1)'(1);
      else if (!wr_en_s && pop_s) count_r <= count_r - (AW+1)'(1);
      else                        count_r <= count_r;

      if (push_s && full_s && !pop_s) overflow_r <= 1'b1;
      else                            overflow_r <= overflow_r;
    end
  end

  assign m_valid  = (count_r != {(AW+1){1'b0}});
  assign m_data   = mem_r[rd_ptr_r][EW-1:2];
  assign m_perr   = mem_r[rd_ptr_r][1];
  assign m_ferr   = mem_r[rd_ptr_r][0];
  assign overflow = overflow_r;

endmodule
